div_bcd_out: RTL and testbench

Downstream result stage for the sequential divider. It captures the quotient and remainder when the divider pulses `done`, and converts both to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then presents the result to the display/UART side through a valid/ready handshake. The divider has no backpressure, so any result that arrives while this block is occupied is dropped and flagged.

---
 rtl/div_bcd_out.sv | 214 +++++++++++++++++++++
 tb/tb_div_bcd_out.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_bcd_out.sv
// div_bcd_out
//   Result stage behind the sequential divider. It captures the quotient and
//   remainder on the divider's done pulse and converts both values to packed
//   BCD with a serial shift-add-3 (double-dabble) engine that takes one bit
//   per cycle. The result is then offered through a valid/ready handshake.
//   The divider cannot be stalled. A done pulse that arrives while a result
//   is being converted or is waiting to be taken is dropped, and the sticky
//   ovf flag records the drop.
//
// Parameters
//   W    binary width of quo/rmd (must match the divider)
//   DIG  BCD digits per value, 10**DIG > 2**W - 1
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   done       one-cycle result strobe from the divider
//   quo, rmd   binary quotient / remainder, valid with done
//   out_ready  consumer accepts the presented result
//   clr_ovf    synchronous clear of ovf (a drop in the same cycle wins)
//   out_valid  BCD result valid (registered)
//   quo_bcd    packed BCD quotient, digit 0 in bits [3:0]
//   rmd_bcd    packed BCD remainder
//   busy       converting or holding a result
//   ovf        sticky: a done pulse was dropped
//
// Build option
//   DIV_BCD_BLANK_EN  when defined, the presented result shows leading zero
//                     digits above digit 0 as 4'hF. When undefined, raw BCD
//                     is presented and no blanking logic is built.
//
// States
//   state   | meaning
//   IDLE    | waiting for done
//   CONV    | shifting one bit per cycle through the add-3 engine
//   HOLD    | result presented, waiting for out_ready

module div_bcd_out #(
  parameter int W   = 4,
  parameter int DIG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [W-1:0]     quo,
  input  logic [W-1:0]     rmd,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [4*DIG-1:0] quo_bcd,
  output logic [4*DIG-1:0] rmd_bcd,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     quo_sr;
  logic [W-1:0]     rmd_sr;
  logic [4*DIG-1:0] quo_acc;
  logic [4*DIG-1:0] rmd_acc;
  logic [CW-1:0]    cnt;

  logic [4*DIG-1:0] quo_acc_nx;
  logic [4*DIG-1:0] rmd_acc_nx;
  logic [4*DIG-1:0] quo_fmt;
  logic [4*DIG-1:0] rmd_fmt;
  logic             xfer;
  logic             capture;
  logic             drop;

  // One double-dabble step: digits >= 5 get +3 independently (no carry
  // between digits, a digit never exceeds 12), then the accumulator shifts
  // left with the next binary bit entering digit 0 bit 0. The top bit
  // shifted out is always zero because 10**DIG covers the input range.
  function automatic logic [4*DIG-1:0] dd_step(input logic [4*DIG-1:0] acc,
                                                input logic             bit_in);
    logic [4*DIG-1:0] adj;
    adj = acc;
    for (int i = 0; i < DIG; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return (adj << 1) | {{(4*DIG-1){1'b0}}, bit_in};
  endfunction

`ifdef DIV_BCD_BLANK_EN
  // Replace leading zero digits with 4'hF, scanning from the top digit down
  // to the first non-zero one. Digit 0 is always shown.
  function automatic logic [4*DIG-1:0] blank_lead(input logic [4*DIG-1:0] val);
    logic [4*DIG-1:0] res;
    logic             lead;
    res  = val;
    lead = 1'b1;
    for (int i = DIG - 1; i > 0; i--) begin
      if (lead && (val[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction
`endif

  always_comb begin
    quo_acc_nx = dd_step(quo_acc, quo_sr[W-1]);
    rmd_acc_nx = dd_step(rmd_acc, rmd_sr[W-1]);
  end

`ifdef DIV_BCD_BLANK_EN
  always_comb begin
    quo_fmt = blank_lead(quo_acc_nx);
    rmd_fmt = blank_lead(rmd_acc_nx);
  end
`else
  always_comb begin
    quo_fmt = quo_acc_nx;
    rmd_fmt = rmd_acc_nx;
  end
`endif

  // out_valid is high exactly in HOLD, so a transfer is just HOLD with ready.
  assign xfer    = out_valid && out_ready;
  assign capture = done && ((state == ST_IDLE) || ((state == ST_HOLD) && xfer));
  assign drop    = done && ((state == ST_CONV) || ((state == ST_HOLD) && !xfer));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      quo_sr    <= '0;
      rmd_sr    <= '0;
      quo_acc   <= '0;
      rmd_acc   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      quo_bcd   <= '0;
      rmd_bcd   <= '0;
    end else begin
      if (capture) begin
        quo_sr  <= quo;
        rmd_sr  <= rmd;
        quo_acc <= '0;
        rmd_acc <= '0;
        cnt     <= CNT_LOAD;
      end

      case (state)
        ST_IDLE: begin
          if (capture) begin
            state <= ST_CONV;
            busy  <= 1'b1;
          end
        end

        ST_CONV: begin
          quo_acc <= quo_acc_nx;
          rmd_acc <= rmd_acc_nx;
          quo_sr  <= quo_sr << 1;
          rmd_sr  <= rmd_sr << 1;
          cnt     <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            // Final step: the presented value is taken straight from the
            // step result so out_valid and the data rise together.
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            quo_bcd   <= quo_fmt;
            rmd_bcd   <= rmd_fmt;
          end
        end

        ST_HOLD: begin
          if (xfer) begin
            out_valid <= 1'b0;
            if (capture) begin
              // Back-to-back: the new operands were loaded above and busy
              // stays high; the old BCD value remains on the outputs.
              state <= ST_CONV;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_bcd_out.sv
module tb_div_bcd_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [3:0]  quo;
  logic [3:0]  rmd;
  logic        out_ready;
  logic        clr_ovf;
  logic        out_valid;
  logic [7:0]  quo_bcd;
  logic [7:0]  rmd_bcd;
  logic        busy;
  logic        ovf;

  logic        done8;
  logic [7:0]  quo8;
  logic [7:0]  rmd8;
  logic        out_valid8;
  logic [11:0] quo_bcd8;
  logic [11:0] rmd_bcd8;
  logic        busy8;
  logic        ovf8;

  int total = 0;
  int bad   = 0;

`ifdef DIV_BCD_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  div_bcd_out #(.W(4), .DIG(2)) u_dut (
    .clk(clk), .rst(rst), .done(done), .quo(quo), .rmd(rmd),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .quo_bcd(quo_bcd), .rmd_bcd(rmd_bcd), .busy(busy), .ovf(ovf)
  );

  div_bcd_out #(.W(8), .DIG(3)) u_dut8 (
    .clk(clk), .rst(rst), .done(done8), .quo(quo8), .rmd(rmd8),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid8),
    .quo_bcd(quo_bcd8), .rmd_bcd(rmd_bcd8), .busy(busy8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; quo = '0; rmd = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    done8 = 1'b0; quo8 = '0; rmd8 = '0;
    tick(); tick();
    total++;
    if ({out_valid, quo_bcd, rmd_bcd, busy, ovf} !== 19'd0) begin
      $display("FAIL reset: got v=%b q=%h r=%h busy=%b ovf=%b, want all 0",
               out_valid, quo_bcd, rmd_bcd, busy, ovf);
      bad++;
    end
    total++;
    if ({out_valid8, quo_bcd8, rmd_bcd8, busy8, ovf8} !== 27'd0) begin
      $display("FAIL reset_w8: got v=%b q=%h r=%h, want all 0", out_valid8, quo_bcd8, rmd_bcd8);
      bad++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    done = 1'b1; quo = 4'd13; rmd = 4'd2;
    tick();
    done = 1'b0;
    total++;
    if ({busy, out_valid} !== 2'b10) begin
      $display("FAIL basic_busy: got busy=%b valid=%b, want 1/0", busy, out_valid);
      bad++;
    end
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    total++;
    if (n !== 4) begin
      $display("FAIL basic_latency: got %0d cycles, want 4", n);
      bad++;
    end
    total++;
    if ({quo_bcd, rmd_bcd, ovf} !== {8'h13, (BLK ? 8'hF2 : 8'h02), 1'b0}) begin
      $display("FAIL basic_value: got q=%h r=%h ovf=%b, want 13/%h/0",
               quo_bcd, rmd_bcd, ovf, (BLK ? 8'hF2 : 8'h02));
      bad++;
    end
    tick();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      $display("FAIL basic_drop: got valid=%b busy=%b, want 0/0", out_valid, busy);
      bad++;
    end
  endtask

  task automatic test_max_blank();
    logic [3:0] vq [3];
    logic [3:0] vr [3];
    logic [7:0] eq [3];
    logic [7:0] er [3];
    int n;
    vq[0] = 4'd15; vr[0] = 4'd0; eq[0] = 8'h15;                 er[0] = BLK ? 8'hF0 : 8'h00;
    vq[1] = 4'd7;  vr[1] = 4'd9; eq[1] = BLK ? 8'hF7 : 8'h07;  er[1] = BLK ? 8'hF9 : 8'h09;
    vq[2] = 4'd0;  vr[2] = 4'd10; eq[2] = BLK ? 8'hF0 : 8'h00; er[2] = 8'h10;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      done = 1'b1; quo = vq[i]; rmd = vr[i];
      tick();
      done = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      total++;
      if ({n[3:0], quo_bcd, rmd_bcd} !== {4'd4, eq[i], er[i]}) begin
        $display("FAIL max_blank[%0d]: got lat=%0d q=%h r=%h, want 4 %h %h",
                 i, n, quo_bcd, rmd_bcd, eq[i], er[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] eq;
    logic [7:0] er;
    eq = BLK ? 8'hF9 : 8'h09;
    er = BLK ? 8'hF3 : 8'h03;
    out_ready = 1'b0;
    done = 1'b1; quo = 4'd9; rmd = 4'd3;
    tick();
    done = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    tick(); tick(); tick();
    total++;
    if ({out_valid, quo_bcd, rmd_bcd} !== {1'b1, eq, er}) begin
      $display("FAIL bp_hold: got v=%b q=%h r=%h, want 1 %h %h", out_valid, quo_bcd, rmd_bcd, eq, er);
      bad++;
    end
    done = 1'b1; quo = 4'd5; rmd = 4'd1;
    tick();
    done = 1'b0;
    total++;
    if ({out_valid, quo_bcd, rmd_bcd, busy, ovf} !== {1'b1, eq, er, 1'b1, 1'b1}) begin
      $display("FAIL bp_overrun: got v=%b q=%h r=%h busy=%b ovf=%b, want 1 %h %h 1 1",
               out_valid, quo_bcd, rmd_bcd, busy, ovf, eq, er);
      bad++;
    end
    done = 1'b1; clr_ovf = 1'b1; quo = 4'd2; rmd = 4'd2;
    tick();
    done = 1'b0; clr_ovf = 1'b0;
    total++;
    if (ovf !== 1'b1) begin
      $display("FAIL bp_set_wins: got ovf=%b, want 1", ovf);
      bad++;
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, busy, ovf} !== 3'b001) begin
      $display("FAIL bp_transfer: got valid=%b busy=%b ovf=%b, want 0 0 1", out_valid, busy, ovf);
      bad++;
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      $display("FAIL bp_clr_ovf: got ovf=%b, want 0", ovf);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    done = 1'b1; quo = 4'd3; rmd = 4'd2;
    tick();
    done = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    total++;
    if ({out_valid, quo_bcd, rmd_bcd} !== {1'b1, (BLK ? 16'hF3F2 : 16'h0302)}) begin
      $display("FAIL b2b_first: got v=%b q=%h r=%h", out_valid, quo_bcd, rmd_bcd);
      bad++;
    end
    out_ready = 1'b1;
    done = 1'b1; quo = 4'd6; rmd = 4'd4;
    tick();
    done = 1'b0;
    total++;
    if ({busy, out_valid, ovf} !== 3'b100) begin
      $display("FAIL b2b_capture: got busy=%b valid=%b ovf=%b, want 1 0 0", busy, out_valid, ovf);
      bad++;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      tick(); n++;
      if (!busy) begin
        total++;
        $display("FAIL b2b_busy: got busy=0 during conversion, want 1");
        bad++;
      end
    end
    total++;
    if ({n[3:0], quo_bcd, rmd_bcd, ovf} !== {4'd4, (BLK ? 16'hF6F4 : 16'h0604), 1'b0}) begin
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h ovf=%b, want 4 %h 0",
               n, quo_bcd, rmd_bcd, ovf, (BLK ? 16'hF6F4 : 16'h0604));
      bad++;
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int n;
    out_ready = 1'b1;
    done = 1'b1; quo = 4'd12; rmd = 4'd11;
    tick();
    done = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, quo_bcd, rmd_bcd, busy, ovf} !== 19'd0) begin
      $display("FAIL midrst_clear: got v=%b q=%h r=%h busy=%b ovf=%b, want all 0",
               out_valid, quo_bcd, rmd_bcd, busy, ovf);
      bad++;
    end
    tick();
    rst = 1'b0;
    tick();
    done = 1'b1; quo = 4'd10; rmd = 4'd1;
    tick();
    done = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    total++;
    if ({n[3:0], quo_bcd, rmd_bcd} !== {4'd4, 8'h10, (BLK ? 8'hF1 : 8'h01)}) begin
      $display("FAIL midrst_after: got lat=%0d q=%h r=%h, want 4 10 %h",
               n, quo_bcd, rmd_bcd, (BLK ? 8'hF1 : 8'h01));
      bad++;
    end
    tick();
  endtask

  task automatic test_w8();
    int n;
    out_ready = 1'b1;
    done8 = 1'b1; quo8 = 8'd255; rmd8 = 8'd100;
    tick();
    done8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 30) begin tick(); n++; end
    total++;
    if ({n[4:0], quo_bcd8, rmd_bcd8} !== {5'd8, 12'h255, 12'h100}) begin
      $display("FAIL w8_value: got lat=%0d q=%h r=%h, want 8 255 100", n, quo_bcd8, rmd_bcd8);
      bad++;
    end
    done8 = 1'b1; quo8 = 8'd7; rmd8 = 8'd40;
    tick();
    done8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 30) begin tick(); n++; end
    total++;
    if ({quo_bcd8, rmd_bcd8} !== (BLK ? 24'hFF7_F40 : 24'h007_040)) begin
      $display("FAIL w8_small: got q=%h r=%h, want %h", quo_bcd8, rmd_bcd8,
               (BLK ? 24'hFF7_F40 : 24'h007_040));
      bad++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_blank();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
